// File: rtl/wb_regfile_hilo.sv
// Writeback register file: 32 GPRs plus HI/LO, committed on the clock edge,
// with combinational read ports that bypass the value being written this cycle.
module wb_regfile_hilo #(
    parameter int REG_W    = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_REGS = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] wb_wd,
    input  logic              wb_wreg,
    input  logic [REG_W-1:0]  wb_wdata,
    input  logic [REG_W-1:0]  wb_hi,
    input  logic [REG_W-1:0]  wb_lo,
    input  logic              wb_whilo,
    input  logic              re1,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [REG_W-1:0]  rdata1,
    input  logic              re2,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [REG_W-1:0]  rdata2,
    output logic [REG_W-1:0]  hi_o,
    output logic [REG_W-1:0]  lo_o
);

    logic [REG_W-1:0] gpr [NUM_REGS];
    logic [REG_W-1:0] hi_q;
    logic [REG_W-1:0] lo_q;

    // GPR0 is never written, so it stays at its reset value of zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                gpr[i] <= '0;
            end
        end else if (wb_wreg && (wb_wd != '0)) begin
            gpr[wb_wd] <= wb_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi_q <= '0;
            lo_q <= '0;
        end else if (wb_whilo) begin
            hi_q <= wb_hi;
            lo_q <= wb_lo;
        end
    end

    always_comb begin
        rdata1 = '0;
        if (!rst && (raddr1 != '0) && re1) begin
            if (wb_wreg && (wb_wd == raddr1)) begin
                rdata1 = wb_wdata;
            end else begin
                rdata1 = gpr[raddr1];
            end
        end
    end

    always_comb begin
        rdata2 = '0;
        if (!rst && (raddr2 != '0) && re2) begin
            if (wb_wreg && (wb_wd == raddr2)) begin
                rdata2 = wb_wdata;
            end else begin
                rdata2 = gpr[raddr2];
            end
        end
    end

    always_comb begin
        hi_o = '0;
        lo_o = '0;
        if (!rst) begin
            hi_o = wb_whilo ? wb_hi : hi_q;
            lo_o = wb_whilo ? wb_lo : lo_q;
        end
    end

endmodule

// File: tb/tb_wb_regfile_hilo.sv
// Self-checking bench for wb_regfile_hilo: directed scenarios plus random
// traffic compared against an array-based reference model.
module tb_wb_regfile_hilo;

    logic        clk;
    logic        rst;
    logic [4:0]  wb_wd;
    logic        wb_wreg;
    logic [31:0] wb_wdata;
    logic [31:0] wb_hi;
    logic [31:0] wb_lo;
    logic        wb_whilo;
    logic        re1;
    logic [4:0]  raddr1;
    logic [31:0] rdata1;
    logic        re2;
    logic [4:0]  raddr2;
    logic [31:0] rdata2;
    logic [31:0] hi_o;
    logic [31:0] lo_o;

    int passed = 0;
    int total  = 0;

    logic [31:0] m_gpr [32];
    logic [31:0] m_hi;
    logic [31:0] m_lo;

    wb_regfile_hilo #(.REG_W(32), .ADDR_W(5), .NUM_REGS(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .wb_wd    (wb_wd),
        .wb_wreg  (wb_wreg),
        .wb_wdata (wb_wdata),
        .wb_hi    (wb_hi),
        .wb_lo    (wb_lo),
        .wb_whilo (wb_whilo),
        .re1      (re1),
        .raddr1   (raddr1),
        .rdata1   (rdata1),
        .re2      (re2),
        .raddr2   (raddr2),
        .rdata2   (rdata2),
        .hi_o     (hi_o),
        .lo_o     (lo_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void model_clear();
        for (int i = 0; i < 32; i++) m_gpr[i] = 32'h0;
        m_hi = 32'h0;
        m_lo = 32'h0;
    endfunction

    // Architectural view of a read port: what an instruction in ID should see.
    function automatic logic [31:0] exp_read(input logic en, input logic [4:0] a);
        if (rst || a == 5'd0 || !en) return 32'h0;
        if (wb_wreg && wb_wd == a) return wb_wdata;
        return m_gpr[a];
    endfunction

    function automatic logic [31:0] exp_hi();
        if (rst) return 32'h0;
        return wb_whilo ? wb_hi : m_hi;
    endfunction

    function automatic logic [31:0] exp_lo();
        if (rst) return 32'h0;
        return wb_whilo ? wb_lo : m_lo;
    endfunction

    // Advance one clock, commit the same write to the model, then move inputs off the edge.
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            model_clear();
        end else begin
            if (wb_wreg && wb_wd != 5'd0) m_gpr[wb_wd] = wb_wdata;
            if (wb_whilo) begin
                m_hi = wb_hi;
                m_lo = wb_lo;
            end
        end
        #1;
    endtask

    task automatic idle_inputs();
        wb_wd = 5'd0; wb_wreg = 1'b0; wb_wdata = 32'h0;
        wb_hi = 32'h0; wb_lo = 32'h0; wb_whilo = 1'b0;
        re1 = 1'b0; raddr1 = 5'd0; re2 = 1'b0; raddr2 = 5'd0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        model_clear();
        tick();
        tick();
        rst = 1'b0;
        #1;
        re1 = 1'b1;
        for (int a = 0; a < 32; a++) begin
            raddr1 = a[4:0];
            #1;
            total++;
            if (rdata1 !== 32'h0) $display("[TB] FAIL reset_gpr%0d: got %h want 00000000", a, rdata1);
            else passed++;
        end
        total++;
        if (hi_o !== 32'h0) $display("[TB] FAIL reset_hi: got %h want 00000000", hi_o); else passed++;
        total++;
        if (lo_o !== 32'h0) $display("[TB] FAIL reset_lo: got %h want 00000000", lo_o); else passed++;
        idle_inputs();
    endtask

    task automatic test_write_read();
        wb_wd = 5'd5; wb_wreg = 1'b1; wb_wdata = 32'hDEADBEEF;
        tick();
        wb_wreg = 1'b0; wb_wdata = 32'h0; wb_wd = 5'd0;
        re1 = 1'b1; raddr1 = 5'd5;
        #1;
        total++;
        if (rdata1 !== 32'hDEADBEEF) $display("[TB] FAIL write_read: got %h want deadbeef", rdata1);
        else passed++;
        re1 = 1'b0;
        #1;
        total++;
        if (rdata1 !== 32'h0) $display("[TB] FAIL read_disabled: got %h want 00000000", rdata1);
        else passed++;
        idle_inputs();
    endtask

    task automatic test_bypass();
        wb_wd = 5'd7; wb_wreg = 1'b1; wb_wdata = 32'h12345678;
        re2 = 1'b1; raddr2 = 5'd7;
        #1;
        total++;
        if (rdata2 !== 32'h12345678) $display("[TB] FAIL bypass_same_cycle: got %h want 12345678", rdata2);
        else passed++;
        tick();
        wb_wreg = 1'b0; wb_wdata = 32'h0; wb_wd = 5'd0;
        #1;
        total++;
        if (rdata2 !== 32'h12345678) $display("[TB] FAIL bypass_stored: got %h want 12345678", rdata2);
        else passed++;
        idle_inputs();
    endtask

    task automatic test_gpr0();
        wb_wd = 5'd0; wb_wreg = 1'b1; wb_wdata = 32'hFFFFFFFF;
        re1 = 1'b1; raddr1 = 5'd0;
        #1;
        total++;
        if (rdata1 !== 32'h0) $display("[TB] FAIL gpr0_bypass: got %h want 00000000", rdata1);
        else passed++;
        tick();
        wb_wreg = 1'b0; wb_wdata = 32'h0;
        #1;
        total++;
        if (rdata1 !== 32'h0) $display("[TB] FAIL gpr0_stored: got %h want 00000000", rdata1);
        else passed++;
        idle_inputs();
    endtask

    task automatic test_hilo();
        wb_whilo = 1'b1; wb_hi = 32'hAAAA0000; wb_lo = 32'h0000BBBB;
        #1;
        total++;
        if (hi_o !== 32'hAAAA0000) $display("[TB] FAIL hi_bypass: got %h want aaaa0000", hi_o); else passed++;
        total++;
        if (lo_o !== 32'h0000BBBB) $display("[TB] FAIL lo_bypass: got %h want 0000bbbb", lo_o); else passed++;
        tick();
        wb_whilo = 1'b0; wb_hi = 32'h13572468; wb_lo = 32'h24681357;
        #1;
        total++;
        if (hi_o !== 32'hAAAA0000) $display("[TB] FAIL hi_hold: got %h want aaaa0000", hi_o); else passed++;
        total++;
        if (lo_o !== 32'h0000BBBB) $display("[TB] FAIL lo_hold: got %h want 0000bbbb", lo_o); else passed++;
        tick();
        #1;
        total++;
        if (hi_o !== 32'hAAAA0000) $display("[TB] FAIL hi_hold2: got %h want aaaa0000", hi_o); else passed++;
        idle_inputs();
    endtask

    task automatic test_async_reset();
        wb_wd = 5'd3; wb_wreg = 1'b1; wb_wdata = 32'h11;
        tick();
        wb_wdata = 32'h22;
        re1 = 1'b1; raddr1 = 5'd3;
        wb_whilo = 1'b1; wb_hi = 32'h5; wb_lo = 32'h6;
        #2;
        rst = 1'b1;
        model_clear();
        #1;
        total++;
        if (rdata1 !== 32'h0) $display("[TB] FAIL async_rst_rdata1: got %h want 00000000", rdata1); else passed++;
        total++;
        if (hi_o !== 32'h0) $display("[TB] FAIL async_rst_hi: got %h want 00000000", hi_o); else passed++;
        total++;
        if (lo_o !== 32'h0) $display("[TB] FAIL async_rst_lo: got %h want 00000000", lo_o); else passed++;
        tick();
        rst = 1'b0;
        wb_wreg = 1'b0; wb_whilo = 1'b0;
        #1;
        total++;
        if (rdata1 !== 32'h0) $display("[TB] FAIL after_rst_gpr3: got %h want 00000000", rdata1); else passed++;
        total++;
        if (hi_o !== 32'h0) $display("[TB] FAIL after_rst_hi: got %h want 00000000", hi_o); else passed++;
        idle_inputs();
    endtask

    task automatic test_random();
        int errs;
        errs = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            wb_wd    = 5'($urandom_range(0, 31));
            wb_wreg  = 1'($urandom_range(0, 1));
            wb_wdata = $urandom;
            wb_whilo = ($urandom_range(0, 3) == 0);
            wb_hi    = $urandom;
            wb_lo    = $urandom;
            re1      = ($urandom_range(0, 7) != 0);
            re2      = ($urandom_range(0, 7) != 0);
            raddr1   = ($urandom_range(0, 3) == 0) ? wb_wd : 5'($urandom_range(0, 31));
            raddr2   = ($urandom_range(0, 3) == 0) ? wb_wd : 5'($urandom_range(0, 31));
            #2;
            total++;
            if (rdata1 !== exp_read(re1, raddr1)) begin
                if (errs < 10) $display("[TB] FAIL rand_rdata1 cyc%0d: got %h want %h", cyc, rdata1, exp_read(re1, raddr1));
                errs++;
            end else passed++;
            total++;
            if (rdata2 !== exp_read(re2, raddr2)) begin
                if (errs < 10) $display("[TB] FAIL rand_rdata2 cyc%0d: got %h want %h", cyc, rdata2, exp_read(re2, raddr2));
                errs++;
            end else passed++;
            total++;
            if (hi_o !== exp_hi() || lo_o !== exp_lo()) begin
                if (errs < 10) $display("[TB] FAIL rand_hilo cyc%0d: got %h/%h want %h/%h", cyc, hi_o, lo_o, exp_hi(), exp_lo());
                errs++;
            end else passed++;
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_bypass();
        test_gpr0();
        test_hilo();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
